irq_priority_ctrl: RTL and testbench
====================================

Name: irq_priority_ctrl

Overview:
- Interrupt controller in front of the CP0 block.
- Synchronises and edge-detects three external interrupt lines, latches them as pending and applies a software mask.
- Arbitrates by fixed priority, drives a stable 3-bit level onto CP0's interruptSignal, and waits for CP0's exceptClear acknowledge.
- Tracks nested in-service levels, retiring them on ERET, so a lower source never preempts a higher one in service.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each irq_in synchroniser (min 2).
- ACK_TIMEOUT, 15, cycles in REQ without int_ack before the request is withdrawn (1..255).

Ports:
- clk  in  1  main clock
- rst  in  1  reset; asynchronous, active-high
- irq_in  in  3  raw asynchronous interrupt lines; bit i has priority level i+1
- mask_we  in  1  mask write strobe
- mask_wdata  in  3  new mask; bit=1 disables the source
- eret  in  1  one-cycle pulse when ERET executes
- int_ack  in  1  CP0 exceptClear; acknowledges the offered level
- exc_active  in  1  internal exception in progress; inhibits new requests
- int_level  out  3  to CP0 interruptSignal; 0 = no request, else 1..3
- pending  out  3  latched pending bits
- mask_q  out  3  current mask
- in_service  out  3  levels currently in service
- timeout_err  out  1  one-cycle pulse on acknowledge timeout

Behaviour:
- Reset values:
  - int_level=0, pending=0, mask_q=0 (all enabled), in_service=0, timeout_err=0.
  - FSM=IDLE, timeout counter=0, synchroniser and edge flops=0.
- Input capture:
  - irq_in passes through SYNC_STAGES flops, then a rising-edge detector.
  - A detected edge sets pending[i] in the cycle after detection.
  - Levels held high do not re-trigger.
  - Set has priority over clear in the same cycle.
- Mask:
  - mask_we writes mask_q the next cycle.
  - Masking never clears pending; it only removes the bit from eligibility.
- Arbitration:
  - eligible = pending & ~mask_q.
  - sel = highest set index; cand_level = sel+1.
  - cur_level = (highest set in_service index)+1, or 0 if none.
- FSM IDLE:
  - int_level=0.
  - If eligible!=0 and cand_level>cur_level and !exc_active and !eret: latch req_idx=sel, int_level<=cand_level, clear counter, go to REQ.
- FSM REQ:
  - int_level is held constant; arbitration changes are ignored until the request leaves REQ.
  - Exits are evaluated in priority order:
    - (1) int_ack: set in_service[req_idx], clear pending[req_idx] (unless a new edge arrives the same cycle), int_level<=0, go to IDLE.
    - (2) exc_active: withdraw; int_level<=0, pending kept, go to IDLE.
    - (3) counter==ACK_TIMEOUT-1: int_level<=0, timeout_err pulses for 1 cycle, pending kept, go to IDLE.
    - (4) otherwise increment counter.
  - If req_idx becomes masked in REQ, the request is still held until one of the exits above.
- eret:
  - Clears the highest set in_service bit; no effect if in_service=0.
  - A request already in REQ is unaffected by eret.
  - IDLE does not issue a request in the eret cycle; re-evaluation happens the next cycle with the updated cur_level.
- Latency:
  - irq_in rise to pending set: SYNC_STAGES+1 cycles.
  - pending to int_level: 1 cycle when IDLE and eligible.
  - Minimum IDLE dwell between requests: 1 cycle.
- Nesting:
  - Up to 3 levels are in service at once.
  - A request equal to or below cur_level is never offered.
- Reset mid-operation returns everything to the reset values immediately; pending edges are lost.

Decomposition:
- Shared package cp0_pkg:
  - CP0 operation codes (MTC=1, MFC=2, ERET=3).
  - Cause codes (Undefined=1, Overflow=2, OutOfRange=4).
  - CP0 register indices (EHB=3, CAUSE=13, EPC=14).
  - IRQ_LEVELS=3 and the FSM state encoding (IDLE, REQ).
- One sub-module, irq_sync_edge: per-line SYNC_STAGES synchroniser plus rising-edge pulse, instantiated three times.

Test Plan:
- Reset, then raise irq_in=3'b010 -> pending=010 after 3 cycles; int_level=2 next cycle. Pulse int_ack -> in_service=010, pending=000, int_level=0.
- While level 2 is in service, raise irq_in[0] -> pending=001 but int_level stays 0. Raise irq_in[2] -> int_level=3. After ack, in_service=110. Pulse eret -> in_service=010; eret again -> 000, then int_level=1 is offered.
- mask_wdata=3'b100 with mask_we, then edge on irq_in[2] -> pending=100, int_level=0. Write mask 000 -> int_level=3 one cycle later.
- Request level 1 and never ack -> int_level=1 for exactly 15 cycles, then 0. timeout_err pulses once, pending=001 is kept, and a re-request follows after 1 IDLE cycle.
- In REQ, assert exc_active -> int_level=0 next cycle, pending kept. Deassert -> re-request.
- Assert rst asynchronously in REQ with in_service=011 -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: operation/cause codes, register indices and the
// interrupt controller's level helpers and FSM encoding.
package cp0_pkg;

    localparam logic [1:0] OP_MTC  = 2'd1;
    localparam logic [1:0] OP_MFC  = 2'd2;
    localparam logic [1:0] OP_ERET = 2'd3;

    localparam logic [2:0] CAUSE_UNDEFINED    = 3'd1;
    localparam logic [2:0] CAUSE_OVERFLOW     = 3'd2;
    localparam logic [2:0] CAUSE_OUT_OF_RANGE = 3'd4;

    localparam logic [4:0] CP0_REG_EHB   = 5'd3;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;

    localparam int IRQ_LEVELS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_e;

    // Level of the highest set bit (index+1), 0 when the vector is empty.
    function automatic logic [2:0] top_level(input logic [IRQ_LEVELS-1:0] v);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < IRQ_LEVELS; i++) begin
            if (v[i]) lvl = 3'(i + 1);
        end
        return lvl;
    endfunction

    function automatic logic [IRQ_LEVELS-1:0] clear_top(input logic [IRQ_LEVELS-1:0] v);
        logic [IRQ_LEVELS-1:0] r;
        logic                  done;
        r    = v;
        done = 1'b0;
        for (int i = IRQ_LEVELS - 1; i >= 0; i--) begin
            if (!done && v[i]) begin
                r[i] = 1'b0;
                done = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: SYNC_STAGES-deep synchroniser followed by a rising-edge
// detector whose pulse is combinational from registered state.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_raw,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_priority_ctrl.sv
// Fixed-priority interrupt controller feeding CP0 interruptSignal, with
// software mask, nested in-service tracking and acknowledge timeout.
module irq_priority_ctrl
    import cp0_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] irq_in,
    input  logic       mask_we,
    input  logic [2:0] mask_wdata,
    input  logic       eret,
    input  logic       int_ack,
    input  logic       exc_active,
    output logic [2:0] int_level,
    output logic [2:0] pending,
    output logic [2:0] mask_q,
    output logic [2:0] in_service,
    output logic       timeout_err
);

    irq_state_e state_q, state_n;
    logic [2:0] rise;
    logic [2:0] pending_q, pending_n, clr;
    logic [2:0] mask_r;
    logic [2:0] isr_q, isr_n;
    logic [2:0] lvl_q, lvl_n;
    logic [1:0] req_idx_q, req_idx_n;
    logic [7:0] cnt_q, cnt_n;
    logic       terr_q, terr_n;
    logic [2:0] eligible, cand_level, cur_level;

    for (genvar g = 0; g < IRQ_LEVELS; g++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst     (rst),
            .irq_raw (irq_in[g]),
            .rise    (rise[g])
        );
    end

    assign eligible   = pending_q & ~mask_r;
    assign cand_level = top_level(eligible);
    assign cur_level  = top_level(isr_q);

    always_comb begin
        state_n   = state_q;
        lvl_n     = lvl_q;
        req_idx_n = req_idx_q;
        cnt_n     = cnt_q;
        terr_n    = 1'b0;
        clr       = 3'b000;
        isr_n     = isr_q;

        if (eret) isr_n = clear_top(isr_q);

        case (state_q)
            IDLE: begin
                lvl_n = 3'd0;
                if (eligible != 3'b000 && cand_level > cur_level && !exc_active && !eret) begin
                    req_idx_n = 2'(cand_level - 3'd1);
                    lvl_n     = cand_level;
                    cnt_n     = 8'd0;
                    state_n   = REQ;
                end
            end
            REQ: begin
                // The offered level is frozen here; only these exits release it.
                if (int_ack) begin
                    isr_n   = isr_n | (3'b001 << req_idx_q);
                    clr     = 3'b001 << req_idx_q;
                    lvl_n   = 3'd0;
                    state_n = IDLE;
                end else if (exc_active) begin
                    lvl_n   = 3'd0;
                    state_n = IDLE;
                end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    lvl_n   = 3'd0;
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: begin
                lvl_n   = 3'd0;
                state_n = IDLE;
            end
        endcase

        // A fresh edge wins over an acknowledge clear of the same bit.
        pending_n = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 3'b000;
            mask_r    <= 3'b000;
            isr_q     <= 3'b000;
            lvl_q     <= 3'd0;
            req_idx_q <= 2'd0;
            cnt_q     <= 8'd0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            pending_q <= pending_n;
            if (mask_we) mask_r <= mask_wdata;
            isr_q     <= isr_n;
            lvl_q     <= lvl_n;
            req_idx_q <= req_idx_n;
            cnt_q     <= cnt_n;
            terr_q    <= terr_n;
        end
    end

    assign int_level   = lvl_q;
    assign pending     = pending_q;
    assign mask_q      = mask_r;
    assign in_service  = isr_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl: per-cycle vector table plus hand
// sequences for acknowledge timeout and asynchronous reset.
module tb_irq_priority_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] irq_in = 3'b000;
    logic       mask_we = 1'b0;
    logic [2:0] mask_wdata = 3'b000;
    logic       eret = 1'b0;
    logic       int_ack = 1'b0;
    logic       exc_active = 1'b0;
    logic [2:0] int_level, pending, mask_q, in_service;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    irq_priority_ctrl #(.SYNC_STAGES(2), .ACK_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .eret        (eret),
        .int_ack     (int_ack),
        .exc_active  (exc_active),
        .int_level   (int_level),
        .pending     (pending),
        .mask_q      (mask_q),
        .in_service  (in_service),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] irq;
        logic       mwe;
        logic [2:0] mwd;
        logic       er;
        logic       ack;
        logic       exc;
        logic [2:0] lvl;
        logic [2:0] pend;
        logic [2:0] isr;
        logic [2:0] mask;
        logic       terr;
    } step_t;

    step_t tbl[$];

    function automatic step_t mk(logic [2:0] irq, logic mwe, logic [2:0] mwd, logic er,
                                 logic ack, logic exc, logic [2:0] lvl, logic [2:0] pend,
                                 logic [2:0] isr, logic [2:0] mask);
        step_t s;
        s.irq = irq; s.mwe = mwe; s.mwd = mwd; s.er = er; s.ack = ack; s.exc = exc;
        s.lvl = lvl; s.pend = pend; s.isr = isr; s.mask = mask; s.terr = 1'b0;
        return s;
    endfunction

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] lvl, input logic [2:0] pend,
                           input logic [2:0] isr, input logic [2:0] mask, input logic terr);
        chk({tag, ".int_level"},   int_level,   lvl);
        chk({tag, ".pending"},     pending,     pend);
        chk({tag, ".in_service"},  in_service,  isr);
        chk({tag, ".mask_q"},      mask_q,      mask);
        chk({tag, ".timeout_err"}, {2'b00, timeout_err}, {2'b00, terr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //               irq    mwe mwd    er ack exc  lvl  pend    isr     mask
        tbl.push_back(mk(3'b010,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b010,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b010,0,3'b000,0,0,0, 3'd0,3'b010,3'b000,3'b000));
        tbl.push_back(mk(3'b010,0,3'b000,0,0,0, 3'd2,3'b010,3'b000,3'b000));
        tbl.push_back(mk(3'b010,0,3'b000,0,1,0, 3'd0,3'b000,3'b010,3'b000));
        tbl.push_back(mk(3'b010,0,3'b000,0,0,0, 3'd0,3'b000,3'b010,3'b000));
        tbl.push_back(mk(3'b011,0,3'b000,0,0,0, 3'd0,3'b000,3'b010,3'b000));
        tbl.push_back(mk(3'b011,0,3'b000,0,0,0, 3'd0,3'b000,3'b010,3'b000));
        tbl.push_back(mk(3'b011,0,3'b000,0,0,0, 3'd0,3'b001,3'b010,3'b000));
        tbl.push_back(mk(3'b011,0,3'b000,0,0,0, 3'd0,3'b001,3'b010,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,0,0,0, 3'd0,3'b001,3'b010,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,0,0,0, 3'd0,3'b001,3'b010,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,0,0,0, 3'd0,3'b101,3'b010,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,0,0,0, 3'd3,3'b101,3'b010,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,0,1,0, 3'd0,3'b001,3'b110,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,1,0,0, 3'd0,3'b001,3'b010,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,1,0,0, 3'd0,3'b001,3'b000,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,0,0,0, 3'd1,3'b001,3'b000,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,0,1,0, 3'd0,3'b000,3'b001,3'b000));
        tbl.push_back(mk(3'b111,0,3'b000,1,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b000,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b000,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b000,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b000,1,3'b100,0,0,0, 3'd0,3'b000,3'b000,3'b100));
        tbl.push_back(mk(3'b100,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b100));
        tbl.push_back(mk(3'b100,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b100));
        tbl.push_back(mk(3'b100,0,3'b000,0,0,0, 3'd0,3'b100,3'b000,3'b100));
        tbl.push_back(mk(3'b100,0,3'b000,0,0,0, 3'd0,3'b100,3'b000,3'b100));
        tbl.push_back(mk(3'b100,1,3'b000,0,0,0, 3'd0,3'b100,3'b000,3'b000));
        tbl.push_back(mk(3'b100,0,3'b000,0,0,0, 3'd3,3'b100,3'b000,3'b000));
        tbl.push_back(mk(3'b100,0,3'b000,0,1,0, 3'd0,3'b000,3'b100,3'b000));
        tbl.push_back(mk(3'b100,0,3'b000,1,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b110,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b110,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b110,0,3'b000,0,0,0, 3'd0,3'b010,3'b000,3'b000));
        tbl.push_back(mk(3'b110,0,3'b000,0,0,0, 3'd2,3'b010,3'b000,3'b000));
        tbl.push_back(mk(3'b110,0,3'b000,0,0,1, 3'd0,3'b010,3'b000,3'b000));
        tbl.push_back(mk(3'b110,0,3'b000,0,0,1, 3'd0,3'b010,3'b000,3'b000));
        tbl.push_back(mk(3'b110,0,3'b000,0,0,0, 3'd2,3'b010,3'b000,3'b000));
        tbl.push_back(mk(3'b110,0,3'b000,0,1,0, 3'd0,3'b000,3'b010,3'b000));
        tbl.push_back(mk(3'b110,0,3'b000,1,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b000,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b000,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));
        tbl.push_back(mk(3'b000,0,3'b000,0,0,0, 3'd0,3'b000,3'b000,3'b000));

        #1;
        chk_all("reset", 3'd0, 3'b000, 3'b000, 3'b000, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            irq_in     = tbl[i].irq;
            mask_we    = tbl[i].mwe;
            mask_wdata = tbl[i].mwd;
            eret       = tbl[i].er;
            int_ack    = tbl[i].ack;
            exc_active = tbl[i].exc;
            tick();
            chk_all($sformatf("step%0d", i), tbl[i].lvl, tbl[i].pend, tbl[i].isr,
                    tbl[i].mask, tbl[i].terr);
        end
        mask_we = 1'b0; eret = 1'b0; int_ack = 1'b0; exc_active = 1'b0;

        // Unacknowledged level-1 request: 15 cycles offered, then timeout.
        irq_in = 3'b001;
        tick(); tick(); tick();
        chk("to.pending_set", pending, 3'b001);
        tick();
        chk("to.level_first", int_level, 3'd1);
        for (int k = 1; k < 15; k++) begin
            tick();
            chk($sformatf("to.level_hold%0d", k), int_level, 3'd1);
            chk($sformatf("to.terr_quiet%0d", k), {2'b00, timeout_err}, 3'b000);
        end
        tick();
        chk_all("to.expire", 3'd0, 3'b001, 3'b000, 3'b000, 1'b1);
        tick();
        chk_all("to.rerequest", 3'd1, 3'b001, 3'b000, 3'b000, 1'b0);

        // Build in_service=011 and leave a level-3 request pending in REQ.
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_all("nest.ack1", 3'd0, 3'b000, 3'b001, 3'b000, 1'b0);
        irq_in = 3'b011;
        tick(); tick(); tick();
        chk("nest.pend2", pending, 3'b010);
        tick();
        chk("nest.lvl2", int_level, 3'd2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_all("nest.ack2", 3'd0, 3'b000, 3'b011, 3'b000, 1'b0);
        irq_in = 3'b111;
        tick(); tick(); tick();
        chk("nest.pend3", pending, 3'b100);
        tick();
        chk("nest.lvl3", int_level, 3'd3);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 3'd0, 3'b000, 3'b000, 3'b000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
